sha256_msg_pack: RTL and testbench

SHA256_MSG_PACK -- requirements
Module: sha256_msg_pack

---
 rtl/sha256_msg_pack.sv | 111 +++++++++++
 tb/tb_sha256_msg_pack.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sha256_msg_pack.sv
// sha256_msg_pack: packs IN_BYTES-wide input beats into 256-bit message
// words for the SHA-256 core. Byte j of a word lands at out_data[8*j+:8].
//
// state | meaning
// IDLE  | cnt == 0, no partial word held
// FILL  | cnt != 0, cnt beats of the current word collected
module sha256_msg_pack #(
    parameter int IN_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*IN_BYTES-1:0] in_data,
    input  logic                  in_vld,
    input  logic                  in_last,
    output logic                  in_rdy,
    input  logic                  flush,
    output logic [255:0]          out_data,
    output logic                  out_vld,
    output logic                  err_short,
    output logic [31:0]           word_cnt,
    output logic [15:0]           err_cnt
);

    localparam int BEATS = 32 / IN_BYTES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = 8 * IN_BYTES;
    localparam logic [CW-1:0] CNT_END = CW'(BEATS - 1);

    logic          in_rdy_q,    in_rdy_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [255:0]  asm_q,       asm_d;
    logic [255:0]  out_data_q,  out_data_d;
    logic          out_vld_q,   out_vld_d;
    logic          err_short_q, err_short_d;
    logic [31:0]   word_cnt_q,  word_cnt_d;
    logic [15:0]   err_cnt_q,   err_cnt_d;

    logic          accept;
    logic [255:0]  full_word;
    int            lane_lsb;

    // Beat acceptance, lane write, word completion and short-word handling.
    always_comb begin
        in_rdy_d    = 1'b1;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_vld_d   = 1'b0;
        err_short_d = 1'b0;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;

        accept    = in_vld && in_rdy_q;
        lane_lsb  = int'(cnt_q) * LW;
        full_word = asm_q;
        full_word[lane_lsb +: LW] = in_data;

        if (flush) begin
            // flush wins over a simultaneous beat; the beat is dropped
            cnt_d = '0;
        end else if (accept) begin
            if (cnt_q == CNT_END) begin
                cnt_d      = '0;
                asm_d      = full_word;
                out_data_d = full_word;
                out_vld_d  = 1'b1;
                word_cnt_d = word_cnt_q + 32'd1;
            end else if (in_last) begin
                cnt_d       = '0;
                err_short_d = 1'b1;
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
                asm_d = full_word;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_rdy_q    <= 1'b0;
            cnt_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            err_short_q <= 1'b0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            in_rdy_q    <= in_rdy_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_vld_q   <= out_vld_d;
            err_short_q <= err_short_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_rdy    = in_rdy_q;
    assign out_data  = out_data_q;
    assign out_vld   = out_vld_q;
    assign err_short = err_short_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sha256_msg_pack.sv
// Directed bench for sha256_msg_pack with IN_BYTES=4.
module tb_sha256_msg_pack;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_vld = 1'b0;
    logic         in_last = 1'b0;
    logic         in_rdy;
    logic         flush = 1'b0;
    logic [255:0] out_data;
    logic         out_vld;
    logic         err_short;
    logic [31:0]  word_cnt;
    logic [15:0]  err_cnt;

    int total = 0;
    int bad = 0;
    int exp_wc = 0;

    sha256_msg_pack #(.IN_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld),
        .in_last(in_last), .in_rdy(in_rdy), .flush(flush),
        .out_data(out_data), .out_vld(out_vld), .err_short(err_short),
        .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte j of word w is (w*32 + j) mod 256, so word 0 has byte j = j.
    function automatic logic [31:0] mk_beat(input int w, input int k);
        logic [31:0] b;
        for (int i = 0; i < 4; i++) b[8*i +: 8] = 8'(w*32 + k*4 + i);
        return b;
    endfunction

    function automatic logic [255:0] mk_word(input int w);
        logic [255:0] r;
        for (int j = 0; j < 32; j++) r[8*j +: 8] = 8'(w*32 + j);
        return r;
    endfunction

    // Drive one beat; returns 1 time unit after the capturing edge.
    task automatic beat(input logic [31:0] d, input logic last, input logic fl);
        in_data = d; in_vld = 1'b1; in_last = last; flush = fl;
        @(posedge clk); #1;
        in_vld = 1'b0; in_last = 1'b0; flush = 1'b0;
    endtask

    task automatic send_word(input int w, input bit gap, input bit last_end);
        for (int k = 0; k < 8; k++) begin
            if (gap && k > 0) begin
                in_data = 32'hDEADBEEF; in_last = 1'b1;
                @(posedge clk); #1;
                in_last = 1'b0;
                chk($sformatf("w%0d_gap%0d_vld", w, k), 256'(out_vld), 256'(0));
            end
            beat(mk_beat(w, k), last_end && (k == 7), 1'b0);
            chk($sformatf("w%0d_b%0d_vld", w, k), 256'(out_vld), 256'(k == 7));
        end
        exp_wc++;
        chk($sformatf("w%0d_data", w), out_data, mk_word(w));
        chk($sformatf("w%0d_err", w), 256'(err_short), 256'(0));
        chk($sformatf("w%0d_wcnt", w), 256'(word_cnt), 256'(exp_wc));
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 256'(in_rdy), 256'(0));
        chk("rst_vld", 256'(out_vld), 256'(0));
        chk("rst_data", out_data, 256'(0));
        chk("rst_wcnt", 256'(word_cnt), 256'(0));
        chk("rst_ecnt", 256'(err_cnt), 256'(0));
        chk("rst_err", 256'(err_short), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", 256'(in_rdy), 256'(1));

        // basic word, then hold
        send_word(0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("w0_vld_drop", 256'(out_vld), 256'(0));
        chk("w0_hold", out_data, mk_word(0));

        // 40 continuous beats: 5 words, pulse every 8 cycles
        for (int w = 1; w <= 5; w++) send_word(w, 1'b0, 1'b0);

        // short word: in_last on third beat
        beat(mk_beat(50, 0), 1'b0, 1'b0);
        beat(mk_beat(50, 1), 1'b0, 1'b0);
        beat(mk_beat(50, 2), 1'b1, 1'b0);
        chk("short_err", 256'(err_short), 256'(1));
        chk("short_vld", 256'(out_vld), 256'(0));
        chk("short_ecnt", 256'(err_cnt), 256'(1));
        chk("short_data_kept", out_data, mk_word(5));
        @(posedge clk); #1;
        chk("short_err_drop", 256'(err_short), 256'(0));
        send_word(6, 1'b0, 1'b0);

        // flush with the 5th beat
        for (int k = 0; k < 4; k++) beat(mk_beat(60, k), 1'b0, 1'b0);
        beat(mk_beat(60, 4), 1'b0, 1'b1);
        chk("flush_err", 256'(err_short), 256'(0));
        chk("flush_vld", 256'(out_vld), 256'(0));
        chk("flush_ecnt", 256'(err_cnt), 256'(1));
        send_word(7, 1'b0, 1'b0);

        // in_last on the final beat is a normal end
        send_word(8, 1'b0, 1'b1);
        chk("last_end_ecnt", 256'(err_cnt), 256'(1));

        // gaps in in_vld with garbage data/last
        send_word(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("gap_vld_drop", 256'(out_vld), 256'(0));

        // reset mid-word, asynchronous clear
        for (int k = 0; k < 4; k++) beat(mk_beat(10, k), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_rdy", 256'(in_rdy), 256'(0));
        chk("arst_data", out_data, 256'(0));
        chk("arst_wcnt", 256'(word_cnt), 256'(0));
        chk("arst_ecnt", 256'(err_cnt), 256'(0));
        chk("arst_vld", 256'(out_vld), 256'(0));
        rst_n = 1'b1;
        exp_wc = 0;
        @(posedge clk); #1;
        chk("arst_rdy_back", 256'(in_rdy), 256'(1));
        send_word(11, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
